// File: rtl/mont_exp_ctrl_if.sv
// Montgomery multiplier handshake: operands and start out, result and done back.
interface mont_exp_ctrl_if #(
   parameter int unsigned WIDTH = 1024
);
   logic             mul_start;
   logic [WIDTH-1:0] mul_a;
   logic [WIDTH-1:0] mul_b;
   logic [WIDTH-1:0] mul_m;
   logic [WIDTH-1:0] mul_result;
   logic             mul_done;

   // Exponentiation controller side
   modport master (
      output mul_start, mul_a, mul_b, mul_m,
      input  mul_result, mul_done
   );

   // Multiplier side
   modport slave (
      input  mul_start, mul_a, mul_b, mul_m,
      output mul_result, mul_done
   );
endinterface

// File: rtl/mont_exp_ctrl.sv
// Left-to-right square-and-multiply exponentiation in the Montgomery domain,
// sequencing an external Montgomery multiplier; a final multiply by 1 returns
// the result to the normal domain.
module mont_exp_ctrl #(
   parameter int unsigned WIDTH   = 1024,
   parameter int unsigned E_WIDTH = 1024,
   parameter int unsigned ELEN_W  = 11
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                start,
   input  logic [WIDTH-1:0]    in_x,
   input  logic [WIDTH-1:0]    in_r,
   input  logic [WIDTH-1:0]    in_m,
   input  logic [E_WIDTH-1:0]  in_e,
   input  logic [ELEN_W-1:0]   in_e_len,
   output logic [WIDTH-1:0]    result,
   output logic                done,
   output logic                busy,
   mont_exp_ctrl_if.master     mul
);

   localparam int unsigned EIDX_W = (E_WIDTH > 1) ? $clog2(E_WIDTH) : 1;

   typedef enum logic [2:0] {
      IDLE, SQ_GO, SQ_WAIT, MUL_GO, MUL_WAIT, FINAL_GO, FINAL_WAIT
   } state_t;

   state_t               state_q, state_d;
   logic [WIDTH-1:0]     acc_q, acc_d;
   logic [WIDTH-1:0]     x_q, x_d;
   logic [WIDTH-1:0]     m_q, m_d;
   logic [E_WIDTH-1:0]   e_q, e_d;
   logic [ELEN_W-1:0]    idx_q, idx_d;
   logic [WIDTH-1:0]     result_q, result_d;
   logic                 done_q, done_d;
   logic                 busy_q, busy_d;
   logic                 mul_start_q, mul_start_d;
   logic [WIDTH-1:0]     mul_a_q, mul_a_d;
   logic [WIDTH-1:0]     mul_b_q, mul_b_d;
   logic [WIDTH-1:0]     mul_m_q, mul_m_d;

   assign result        = result_q;
   assign done          = done_q;
   assign busy          = busy_q;
   assign mul.mul_start = mul_start_q;
   assign mul.mul_a     = mul_a_q;
   assign mul.mul_b     = mul_b_q;
   assign mul.mul_m     = mul_m_q;

   // State and datapath registers with synchronous reset
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         acc_q       <= '0;
         x_q         <= '0;
         m_q         <= '0;
         e_q         <= '0;
         idx_q       <= '0;
         result_q    <= '0;
         done_q      <= 1'b0;
         busy_q      <= 1'b0;
         mul_start_q <= 1'b0;
         mul_a_q     <= '0;
         mul_b_q     <= '0;
         mul_m_q     <= '0;
      end else begin
         state_q     <= state_d;
         acc_q       <= acc_d;
         x_q         <= x_d;
         m_q         <= m_d;
         e_q         <= e_d;
         idx_q       <= idx_d;
         result_q    <= result_d;
         done_q      <= done_d;
         busy_q      <= busy_d;
         mul_start_q <= mul_start_d;
         mul_a_q     <= mul_a_d;
         mul_b_q     <= mul_b_d;
         mul_m_q     <= mul_m_d;
      end
   end

   // Next-state and operand sequencing; operands only change in GO states
   always_comb begin
      state_d     = state_q;
      acc_d       = acc_q;
      x_d         = x_q;
      m_d         = m_q;
      e_d         = e_q;
      idx_d       = idx_q;
      result_d    = result_q;
      done_d      = 1'b0;
      busy_d      = busy_q;
      mul_start_d = 1'b0;
      mul_a_d     = mul_a_q;
      mul_b_d     = mul_b_q;
      mul_m_d     = mul_m_q;

      unique case (state_q)
         IDLE: begin
            // done_q high means the completion cycle; a start there is dropped
            if (start && !done_q) begin
               x_d     = in_x;
               m_d     = in_m;
               e_d     = in_e;
               idx_d   = in_e_len;
               acc_d   = in_r;
               busy_d  = 1'b1;
               state_d = (in_e_len == '0) ? FINAL_GO : SQ_GO;
            end
         end
         SQ_GO: begin
            idx_d       = idx_q - ELEN_W'(1);
            mul_a_d     = acc_q;
            mul_b_d     = acc_q;
            mul_m_d     = m_q;
            mul_start_d = 1'b1;
            state_d     = SQ_WAIT;
         end
         SQ_WAIT: begin
            if (mul.mul_done) begin
               acc_d = mul.mul_result;
               if (e_q[idx_q[EIDX_W-1:0]]) begin
                  state_d = MUL_GO;
               end else if (idx_q == '0) begin
                  state_d = FINAL_GO;
               end else begin
                  state_d = SQ_GO;
               end
            end
         end
         MUL_GO: begin
            mul_a_d     = acc_q;
            mul_b_d     = x_q;
            mul_m_d     = m_q;
            mul_start_d = 1'b1;
            state_d     = MUL_WAIT;
         end
         MUL_WAIT: begin
            if (mul.mul_done) begin
               acc_d   = mul.mul_result;
               state_d = (idx_q == '0) ? FINAL_GO : SQ_GO;
            end
         end
         FINAL_GO: begin
            mul_a_d     = acc_q;
            mul_b_d     = WIDTH'(1);
            mul_m_d     = m_q;
            mul_start_d = 1'b1;
            state_d     = FINAL_WAIT;
         end
         FINAL_WAIT: begin
            if (mul.mul_done) begin
               result_d = mul.mul_result;
               done_d   = 1'b1;
               busy_d   = 1'b0;
               state_d  = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

endmodule
